// File: rtl/matrix_core_if.sv
// Request/result bundle for the point-transform core: a single-entry
// request handshake on the way in and a two-beat (x' then y') result
// stream on the way out.
interface matrix_core_if #(
  parameter int DATA_WIDTH = 8
);

  logic                         req_valid;
  logic                         req_ready;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic [1:0]                   transform_type;
  logic signed [DATA_WIDTH-1:0] param1;
  logic signed [DATA_WIDTH-1:0] param2;
  logic [2*DATA_WIDTH-1:0]      matrix_result;
  logic                         matrix_valid;
  logic                         sat_flag;
  logic                         busy;

  // Requester side: issues points and parameters, observes result beats.
  modport master (
    output req_valid, x_in, y_in, transform_type, param1, param2,
    input  req_ready, matrix_result, matrix_valid, sat_flag, busy
  );

  // Core side: accepts requests, produces result beats.
  modport slave (
    input  req_valid, x_in, y_in, transform_type, param1, param2,
    output req_ready, matrix_result, matrix_valid, sat_flag, busy
  );

endinterface

// File: rtl/matrix_core.sv
// 2-D point transform core (rotate / scale / translate / shear).
// A request is latched on acceptance, then four CALC cycles feed one shared
// signed multiplier (p1*x, p2*y, p2*x, p1*y), then x' and y' are emitted as
// two saturated, sign-extended beats. Every transform type uses the same
// fixed 6-cycle schedule, so the result latency never depends on the type.
module matrix_core #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 6
) (
  input  logic           clk,
  input  logic           rst,
  matrix_core_if.slave   bus
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int EW = 2 * DATA_WIDTH + 2;

  // Clipping bounds held at the wide internal width so every transform can
  // be compared against them without further casting.
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    OUT_X = 2'd2,
    OUT_Y = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    T_ROTATE    = 2'b00,
    T_SCALE     = 2'b01,
    T_TRANSLATE = 2'b10,
    T_SHEAR     = 2'b11
  } xform_t;

  state_t               state_q;
  logic [1:0]           cnt_q;
  xform_t               type_q;
  logic signed [W-1:0]  x_q;
  logic signed [W-1:0]  y_q;
  logic signed [W-1:0]  p1_q;
  logic signed [W-1:0]  p2_q;
  logic signed [PW-1:0] prod0_q;
  logic signed [PW-1:0] prod1_q;
  logic signed [PW-1:0] prod2_q;
  logic signed [PW-1:0] prod3_q;

  logic                 ready_q;
  logic                 busy_q;
  logic                 valid_q;
  logic                 sat_q;
  logic [PW-1:0]        result_q;

  logic signed [W-1:0]  mul_a;
  logic signed [W-1:0]  mul_b;
  logic signed [PW-1:0] mul_p;
  logic signed [PW-1:0] prod3_eff;

  logic signed [EW-1:0] rot_x_sum;
  logic signed [EW-1:0] rot_y_sum;
  logic signed [EW-1:0] x_wide;
  logic signed [EW-1:0] y_wide;
  logic [W:0]           x_sat;
  logic [W:0]           y_sat;

  // Clip a wide result into the signed DATA_WIDTH range; the MSB of the
  // return value reports whether clipping happened.
  function automatic logic [W:0] saturate(input logic signed [EW-1:0] v);
    logic [W:0] r;
    if (v > SAT_MAX) begin
      r = {1'b1, SAT_MAX[W-1:0]};
    end else if (v < SAT_MIN) begin
      r = {1'b1, SAT_MIN[W-1:0]};
    end else begin
      r = {1'b0, v[W-1:0]};
    end
    return r;
  endfunction

  // Operand select for the single shared multiplier, one product per CALC cycle.
  always_comb begin
    mul_a = p1_q;
    mul_b = x_q;
    unique case (cnt_q)
      2'd0: begin mul_a = p1_q; mul_b = x_q; end
      2'd1: begin mul_a = p2_q; mul_b = y_q; end
      2'd2: begin mul_a = p2_q; mul_b = x_q; end
      2'd3: begin mul_a = p1_q; mul_b = y_q; end
      default: begin mul_a = p1_q; mul_b = x_q; end
    endcase
  end

  assign mul_p = PW'(mul_a) * PW'(mul_b);

  // x' is registered on the last CALC edge, the same edge that stores p1*y,
  // so shear's x' takes that product straight from the multiplier.
  assign prod3_eff = (state_q == CALC && cnt_q == 2'd3) ? mul_p : prod3_q;

  assign rot_x_sum = EW'(prod0_q) - EW'(prod1_q);
  assign rot_y_sum = EW'(prod2_q) + EW'(prod3_q);

  // Per-type result arithmetic at full width, ahead of saturation.
  always_comb begin
    x_wide = '0;
    y_wide = '0;
    unique case (type_q)
      T_ROTATE: begin
        x_wide = rot_x_sum >>> FRAC_BITS;
        y_wide = rot_y_sum >>> FRAC_BITS;
      end
      T_SCALE: begin
        x_wide = EW'(prod0_q);
        y_wide = EW'(prod1_q);
      end
      T_TRANSLATE: begin
        x_wide = EW'(x_q) + EW'(p1_q);
        y_wide = EW'(y_q) + EW'(p2_q);
      end
      T_SHEAR: begin
        x_wide = EW'(x_q) + EW'(prod3_eff);
        y_wide = EW'(y_q) + EW'(prod2_q);
      end
      default: begin
        x_wide = '0;
        y_wide = '0;
      end
    endcase
  end

  assign x_sat = saturate(x_wide);
  assign y_sat = saturate(y_wide);

  // Sequencer: latch request, run four multiply cycles, emit x' then y'.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      type_q   <= T_ROTATE;
      x_q      <= '0;
      y_q      <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      prod0_q  <= '0;
      prod1_q  <= '0;
      prod2_q  <= '0;
      prod3_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          valid_q  <= 1'b0;
          sat_q    <= 1'b0;
          result_q <= '0;
          if (bus.req_valid) begin
            x_q     <= bus.x_in;
            y_q     <= bus.y_in;
            p1_q    <= bus.param1;
            p2_q    <= bus.param2;
            type_q  <= xform_t'(bus.transform_type);
            cnt_q   <= 2'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          unique case (cnt_q)
            2'd0: prod0_q <= mul_p;
            2'd1: prod1_q <= mul_p;
            2'd2: prod2_q <= mul_p;
            2'd3: prod3_q <= mul_p;
            default: prod0_q <= mul_p;
          endcase
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q  <= OUT_X;
            valid_q  <= 1'b1;
            sat_q    <= x_sat[W];
            result_q <= {{W{x_sat[W-1]}}, x_sat[W-1:0]};
          end
        end
        OUT_X: begin
          state_q  <= OUT_Y;
          valid_q  <= 1'b1;
          sat_q    <= y_sat[W];
          result_q <= {{W{y_sat[W-1]}}, y_sat[W-1:0]};
        end
        OUT_Y: begin
          state_q  <= IDLE;
          valid_q  <= 1'b0;
          sat_q    <= 1'b0;
          result_q <= '0;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.busy          = busy_q;
  assign bus.matrix_valid  = valid_q;
  assign bus.sat_flag      = sat_q;
  assign bus.matrix_result = result_q;

endmodule
